// File: rtl/multiplier_arbiter_if.sv
// multiplier_arbiter_if: request/response bundle between requesters, consumer and multiplier_arbiter.
// Latency: none, wiring only.
// Backpressure: req_ready is the per-requester grant; rsp_ready=0 stalls the whole arbiter pipeline.
// Signals: req_valid/req_ready/req_signed (one bit per requester), req_a/req_b packed with
//          requester i at [i*W +: W], rsp_valid/rsp_ready/rsp_id/rsp_data single result port.
// Modports: master = requesters + consumer side, slave = arbiter side.
interface multiplier_arbiter_if #(
  parameter int NB_REQ   = 4,
  parameter int ID_WIDTH = 2,
  parameter int WIDTH_A  = 16,
  parameter int WIDTH_B  = 16
);
  logic [NB_REQ-1:0]          req_valid;
  logic [NB_REQ-1:0]          req_ready;
  logic [NB_REQ-1:0]          req_signed;
  logic [NB_REQ*WIDTH_A-1:0]  req_a;
  logic [NB_REQ*WIDTH_B-1:0]  req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic [WIDTH_A+WIDTH_B-1:0] rsp_data;

  modport master (
    output req_valid, req_signed, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_signed, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: shares one pipelined signed/unsigned multiplier between NB_REQ requesters.
// Latency: LAT = NB_EXTRA_REG+1 enabled cycles from grant to rsp_valid; one grant per cycle.
// Backpressure: rsp_valid & ~rsp_ready freezes every pipeline stage and forces all req_ready low.
// Ports: clk, rst (async, active-high), bus (multiplier_arbiter_if.slave).
// Build option: MULTIPLIER_ARBITER_RR_EN defined selects round-robin arbitration; undefined
//               selects fixed priority (lowest valid index wins).

// multiplier: full-width product, both operands two's complement when is_signed is set.
// Latency: NB_EXTRA_REG+1 registers, all advancing together on enable.
// Backpressure: enable=0 holds every stage; datapath has no reset.
module multiplier #(
  parameter int WIDTH_A      = 16,
  parameter int WIDTH_B      = 16,
  parameter int NB_EXTRA_REG = 1
) (
  input  logic                       clk,
  input  logic                       enable,
  input  logic                       is_signed,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic [WIDTH_A+WIDTH_B-1:0] out
);
  localparam int LAT = NB_EXTRA_REG + 1;
  localparam int RW  = WIDTH_A + WIDTH_B;

  logic signed [WIDTH_A:0] a_ext;
  logic signed [WIDTH_B:0] b_ext;
  logic signed [RW-1:0]    prod;
  logic [RW-1:0]           pipe [LAT];

  // One extra top bit turns unsigned operands into non-negative signed ones, so a single
  // signed multiply covers both modes. Only the low RW bits of the product are meaningful.
  assign a_ext = {is_signed & a[WIDTH_A-1], a};
  assign b_ext = {is_signed & b[WIDTH_B-1], b};
  assign prod  = RW'(a_ext) * RW'(b_ext);

  always_ff @(posedge clk) begin
    if (enable) begin
      pipe[0] <= prod;
      for (int s = 1; s < LAT; s++) begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

  assign out = pipe[LAT-1];
endmodule

module multiplier_arbiter #(
  parameter int NB_REQ       = 4,
  parameter int ID_WIDTH     = 2,
  parameter int WIDTH_A      = 16,
  parameter int WIDTH_B      = 16,
  parameter int NB_EXTRA_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  multiplier_arbiter_if.slave  bus
);
  localparam int LAT   = NB_EXTRA_REG + 1;
  localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  logic                stall;
  logic                enable;
  logic                grant_any;
  logic                grant_fire;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] search_base;
  logic [NB_REQ-1:0]   ready_vec;
  int                  cand;

  logic [WIDTH_A-1:0]  a_arr [NB_REQ];
  logic [WIDTH_B-1:0]  b_arr [NB_REQ];
  logic [WIDTH_A-1:0]  mul_a;
  logic [WIDTH_B-1:0]  mul_b;
  logic                mul_signed;

  logic                tag_vld [LAT];
  logic [ID_WIDTH-1:0] tag_id  [LAT];

  assign stall      = bus.rsp_valid & ~bus.rsp_ready;
  assign enable     = ~stall;
  // rst is asynchronous, so the combinational grant is masked directly to keep req_ready low
  // for the whole reset window, not just from the next edge.
  assign grant_fire = grant_any & enable & ~rst;

  for (genvar i = 0; i < NB_REQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[i*WIDTH_A +: WIDTH_A];
    assign b_arr[i] = bus.req_b[i*WIDTH_B +: WIDTH_B];
  end

`ifdef MULTIPLIER_ARBITER_RR_EN
  // Points at the requester after the last one granted; search starts here.
  logic [ID_WIDTH-1:0] rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= (grant_idx == ID_WIDTH'(NB_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end
  end

  assign search_base = rr_ptr;
`else
  assign search_base = '0;
`endif

  // First valid requester at or after search_base, wrapping modulo NB_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < NB_REQ; k++) begin
      cand = int'(search_base) + k;
      if (cand >= NB_REQ) begin
        cand = cand - NB_REQ;
      end
      if (!grant_any && bus.req_valid[cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (grant_fire) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  assign bus.req_ready = ready_vec;

  // Without a grant the multiplier sees 0 * 0 unsigned, so idle slots carry a known product.
  always_comb begin
    mul_a      = '0;
    mul_b      = '0;
    mul_signed = 1'b0;
    if (grant_fire) begin
      mul_a      = a_arr[grant_idx];
      mul_b      = b_arr[grant_idx];
      mul_signed = bus.req_signed[grant_idx];
    end
  end

  multiplier #(
    .WIDTH_A      (WIDTH_A),
    .WIDTH_B      (WIDTH_B),
    .NB_EXTRA_REG (NB_EXTRA_REG)
  ) u_mul (
    .clk       (clk),
    .enable    (enable),
    .is_signed (mul_signed),
    .a         (mul_a),
    .b         (mul_b),
    .out       (bus.rsp_data)
  );

  // Tag pipeline mirrors the multiplier stage for stage; bubbles are kept, never collapsed,
  // so tag and product stay aligned through stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        tag_vld[s] <= 1'b0;
        tag_id[s]  <= '0;
      end
    end else if (enable) begin
      tag_vld[0] <= grant_fire;
      tag_id[0]  <= grant_fire ? grant_idx : '0;
      for (int s = 1; s < LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  assign bus.rsp_valid = tag_vld[LAT-1];
  assign bus.rsp_id    = tag_id[LAT-1];
endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter: randomized + directed stimulus against a queue-based reference model.
// Driver predicts grants/rsp_valid and pushes expected results; monitor pops on each handshake.
module tb_multiplier_arbiter;
  localparam int NB  = 4;
  localparam int IDW = 2;
  localparam int WA  = 16;
  localparam int WB  = 16;
  localparam int NX  = 1;
  localparam int LAT = NX + 1;
  localparam int RW  = WA + WB;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multiplier_arbiter_if #(.NB_REQ(NB), .ID_WIDTH(IDW), .WIDTH_A(WA), .WIDTH_B(WB)) bus ();

  multiplier_arbiter #(
    .NB_REQ(NB), .ID_WIDTH(IDW), .WIDTH_A(WA), .WIDTH_B(WB), .NB_EXTRA_REG(NX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            id;
    logic [RW-1:0] data;
  } exp_t;

  exp_t sb[$];      // expected results in grant order
  int   waits[$];   // per in-flight result: enabled edges left before it is visible
  int   m_ptr;      // model round-robin pointer
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [RW-1:0] ref_mul(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                            input logic sgn);
    longint x, y;
    x = sgn ? longint'($signed(a)) : longint'(a);
    y = sgn ? longint'($signed(b)) : longint'(b);
    return RW'(x * y);
  endfunction

  // One clock of stimulus plus model prediction and model advance.
  task automatic cycle(input logic [NB-1:0] v, input logic [NB-1:0] s,
                       input logic [NB*WA-1:0] a, input logic [NB*WB-1:0] b, input logic rr);
    logic          m_valid, stall, found;
    int            gi, start;
    logic [NB-1:0] exp_ready;
    @(negedge clk);
    bus.req_valid  = v;
    bus.req_signed = s;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.rsp_ready  = rr;
    #1;
    m_valid = !rst && waits.size() > 0 && waits[0] == 0;
    stall   = m_valid && !rr;
    found   = 1'b0;
    gi      = 0;
`ifdef MULTIPLIER_ARBITER_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NB; k++) begin
      int c;
      c = (start + k) % NB;
      if (!found && v[c]) begin
        found = 1'b1;
        gi    = c;
      end
    end
    exp_ready = '0;
    if (found && !stall && !rst) exp_ready[gi] = 1'b1;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    if (exp_ready != '0) sb.push_back('{gi, ref_mul(a[gi*WA +: WA], b[gi*WB +: WB], s[gi])});
    @(posedge clk);
    if (!rst && !stall) begin
      if (m_valid && rr) void'(waits.pop_front());
      foreach (waits[k]) if (waits[k] > 0) waits[k]--;
      if (exp_ready != '0) begin
        waits.push_back(LAT - 1);
        m_ptr = (gi + 1) % NB;
      end
    end
  endtask

  task automatic one(input int idx, input logic [WA-1:0] a, input logic [WB-1:0] b,
                     input logic sgn);
    logic [NB*WA-1:0] pa;
    logic [NB*WB-1:0] pb;
    logic [NB-1:0]    v, s;
    pa = '0; pb = '0; v = '0; s = '0;
    pa[idx*WA +: WA] = a;
    pb[idx*WB +: WB] = b;
    v[idx] = 1'b1;
    s[idx] = sgn;
    cycle(v, s, pa, pb, 1'b1);
  endtask

  task automatic idle(input int n, input logic rr);
    repeat (n) cycle('0, '0, '0, '0, rr);
  endtask

  task automatic all_valid(input int n, input logic rr);
    repeat (n) cycle('1, NB'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, rr);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    sb.delete();
    waits.delete();
    m_ptr = 0;
    all_valid(n, 1'b1);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stability while stalled.
  initial begin
    logic           pst;
    logic [IDW-1:0] pid;
    logic [RW-1:0]  pdat;
    pst = 1'b0; pid = '0; pdat = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pst = 1'b0;
      end else begin
        if (pst) begin
          chk("hold_valid", 64'(bus.rsp_valid), 64'(1));
          chk("hold_id", 64'(bus.rsp_id), 64'(pid));
          chk("hold_data", 64'(bus.rsp_data), 64'(pdat));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_rsp: got id %0d data %0h expected no result",
                     bus.rsp_id, bus.rsp_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
            chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
          end
        end
        pst  = bus.rsp_valid && !bus.rsp_ready;
        pid  = bus.rsp_id;
        pdat = bus.rsp_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    m_ptr          = 0;
    bus.req_valid  = '1;
    bus.req_signed = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b1;
    #3;
    chk("init_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("init_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("init_req_ready", 64'(bus.req_ready), 64'(0));
    all_valid(2, 1'b1);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;

    // Contention right after reset: RR sequence starts at requester 0.
    all_valid(8, 1'b1);
    idle(3, 1'b1);

    // Basic unsigned, signed, and the 0xFFFF corner in both modes.
    one(0, 16'd3, 16'd5, 1'b0);
    idle(3, 1'b1);
    one(2, 16'hFFFE, 16'h0003, 1'b1);
    idle(3, 1'b1);
    one(0, 16'hFFFF, 16'hFFFF, 1'b0);
    one(0, 16'hFFFF, 16'hFFFF, 1'b1);
    idle(3, 1'b1);

    // Backpressure: two in flight, then 5 stalled cycles with every requester asking.
    one(0, 16'h1234, 16'h5678, 1'b0);
    one(1, 16'h8000, 16'h7FFF, 1'b1);
    all_valid(5, 1'b0);
    idle(4, 1'b1);

    // Reset with two results in flight, then RR restarts at requester 0.
    one(3, 16'd7, 16'd9, 1'b0);
    one(1, 16'd11, 16'd13, 1'b0);
    do_reset(2);
    all_valid(4, 1'b1);
    idle(3, 1'b1);

    // Idle bubbles: requester 1 every third cycle.
    repeat (4) begin
      one(1, 16'($urandom), 16'($urandom), 1'($urandom));
      idle(2, 1'b1);
    end

    // Randomized traffic with random backpressure.
    repeat (2000) begin
      cycle(NB'($urandom), NB'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 3) != 0));
    end

    idle(LAT + 3, 1'b1);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Shares one pipelined signed/unsigned `multiplier` between `NB_REQ` requesters. Each requester offers an operand pair with a valid/ready handshake; the block grants at most one per cycle, issues it to the internal multiplier, and tracks a requester tag through the multiplier pipeline. Results return on a single response port with backpressure; an output stall freezes the whole pipeline through the multiplier `enable`.

## Interface
- `NB_REQ`, 4: number of requesters (≥2)
- `ID_WIDTH`, 2: tag width, ≥ clog2(`NB_REQ`)
- `WIDTH_A`, 16: operand A width
- `WIDTH_B`, 16: operand B width
- `NB_EXTRA_REG`, 1: extra multiplier pipeline registers; latency `LAT` = `NB_EXTRA_REG`+1
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NB_REQ  per-requester operand valid
- `req_ready`  out  NB_REQ  per-requester grant, one-hot or zero
- `req_signed`  in  NB_REQ  per-requester signed-multiply select
- `req_a`  in  NB_REQ*WIDTH_A  operand A, requester i at bits [i*WIDTH_A +: WIDTH_A]
- `req_b`  in  NB_REQ*WIDTH_B  operand B, same packing
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  ID_WIDTH  index of the requester owning the result
- `rsp_data`  out  WIDTH_A+WIDTH_B  product

## Operation
- `stall` = `rsp_valid` & ~`rsp_ready`. Multiplier `enable` = ~`stall`.
- Arbitration is combinational. `req_ready[i]` is high only when the following hold: ~`stall`, `req_valid[i]`, and i is the selected requester. `req_valid` must not depend on `req_ready`.
- A transfer happens on a clock edge where `req_valid[i]` & `req_ready[i]`. That requester's `req_a`, `req_b` and `req_signed` are muxed to the multiplier.
- With no grant, the multiplier inputs are driven to 0, unsigned.
- Tag pipeline: `LAT` stages of {valid, id}, advancing only when `enable`=1. Stage 0 loads {grant_any, grant_idx}. The last stage drives `rsp_valid`/`rsp_id`. `rsp_data` is the multiplier `out`.
- Bubbles travel through the pipeline. There is no bubble collapse, so a stall freezes every stage.
- Products are full width, with no truncation. Signed mode is two's complement: A and B are both signed.
- The multiplier datapath has no reset. Garbage in the datapath is masked by the tag valid bits, which are reset.
- Reset, including mid-operation: all tag valids are cleared and in-flight results are dropped. The round-robin pointer goes to 0.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `req_ready`=0 while `rst` is high. `rsp_data` is undefined until the first valid result.
- Latency: a request accepted at edge T produces `rsp_valid`=1 after edge T+`LAT-1`, visible in the cycle following that edge. This assumes no stall cycles in between. Each stall cycle adds one cycle.
- Throughput: one request per cycle while `rsp_ready`=1.
- While stalled: `rsp_valid`, `rsp_id` and `rsp_data` hold stable, and all `req_ready`=0.
- Ordering: results leave strictly in grant order.
- A result is consumed at an edge with `rsp_valid` & `rsp_ready`. A new grant may happen in that same cycle.

## Configuration
- `MULTIPLIER_ARBITER_RR_EN`, defined: round-robin arbitration.
  - A pointer holds the index after the last granted requester. The search starts at the pointer and wraps modulo `NB_REQ`.
  - The pointer updates only on a grant.
- Undefined: fixed priority, where the lowest valid index wins. The pointer logic is absent.

## Test plan
Defaults, `LAT`=2.
- Basic unsigned: req0 sends a=3, b=5, unsigned, with `rsp_ready`=1. Expect `rsp_valid` with id=0 and data=0x0000000F two cycles after acceptance.
- Signed: req2 sends a=0xFFFE, b=0x0003, signed. Expect id=2, data=0xFFFFFFFA.
  - a=b=0xFFFF unsigned gives 0xFFFE0001; signed gives 0x00000001.
- Contention: all four `req_valid` held high with `rsp_ready`=1.
  - RR build: grants run 0,1,2,3,0,1…, and rsp_id follows the same sequence two cycles later.
  - Non-RR build: only requester 0 is granted.
- Backpressure: two results in flight, then `rsp_ready`=0 for 5 cycles.
  - rsp_valid, rsp_id and rsp_data stay frozen, and `req_ready`=0.
  - After release, both results appear on consecutive cycles in order, with none lost or duplicated.
- Reset mid-stream: assert `rst` with 2 results in flight.
  - `rsp_valid`=0 immediately (async) and stays 0 after release, until new grants complete.
  - The first RR grant after reset goes to requester 0.
- Idle bubbles: req1 sends a request every third cycle. Each response appears exactly 2 cycles after its acceptance, with `rsp_valid`=0 in between.
